// File: rtl/int_to_rec_fn_iter_pkg.sv
// Shared constants, FSM state enum and leading-zero helper for the iterative
// integer to recoded-double converter.
package int_to_rec_fn_pkg;

    localparam int INT_W        = 64;
    localparam int SIG_W        = 53;
    localparam int REC_W        = 65;
    localparam int REC_EXP_BIAS = 2048;

    localparam logic [2:0] RM_NEAR_EVEN   = 3'd0;
    localparam logic [2:0] RM_MIN_MAG     = 3'd1;
    localparam logic [2:0] RM_MIN         = 3'd2;
    localparam logic [2:0] RM_MAX         = 3'd3;
    localparam logic [2:0] RM_NEAR_MAXMAG = 3'd4;
    localparam logic [2:0] RM_ODD         = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Zero maps to 63 so a zero operand simply stays zero after shifting.
    function automatic logic [5:0] lzc64(input logic [INT_W-1:0] v);
        lzc64 = 6'd63;
        for (int i = 0; i < INT_W; i++) begin
            if (v[i]) lzc64 = 6'(63 - i);
        end
    endfunction

endpackage

// File: rtl/int_to_rec_fn_iter_if.sv
// Request/response handshake bundle between a requester (master) and the
// converter (slave).
interface int_to_rec_fn_iter_if import int_to_rec_fn_pkg::*; ();

    logic             io_in_valid;
    logic             io_in_ready;
    logic [INT_W-1:0] io_in_bits_in;
    logic             io_in_bits_signedIn;
    logic [2:0]       io_in_bits_roundingMode;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [REC_W-1:0] io_out_bits_out;
    logic [4:0]       io_out_bits_exceptionFlags;

    modport master (
        output io_in_valid, io_in_bits_in, io_in_bits_signedIn, io_in_bits_roundingMode,
        output io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_out, io_out_bits_exceptionFlags
    );

    modport slave (
        input  io_in_valid, io_in_bits_in, io_in_bits_signedIn, io_in_bits_roundingMode,
        input  io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_out, io_out_bits_exceptionFlags
    );

endinterface

// File: rtl/int_to_rec_fn_iter_round_pack.sv
// Combinational rounding of a normalized 64-bit magnitude to 53 bits and
// packing into the 65-bit recoded double format.
module rec_fn_round_pack
    import int_to_rec_fn_pkg::*;
(
    input  logic [INT_W-1:0] norm,
    input  logic [5:0]       shiftCount,
    input  logic             sign,
    input  logic [2:0]       roundingMode,
    output logic [REC_W-1:0] recOut,
    output logic [4:0]       exceptionFlags
);

    logic              guardBit;
    logic              stickyBit;
    logic              inexact;
    logic              roundUp;
    logic [SIG_W-1:0]  fracSum;
    logic              carryOut;
    logic [SIG_W-2:0]  fracOut;
    logic [11:0]       expOut;

    // The hidden bit is norm[63]; adding to the fraction alone and taking its
    // carry is the same as carrying out of the full 53-bit significand.
    always_comb begin
        guardBit  = norm[10];
        stickyBit = |norm[9:0];
        inexact   = guardBit | stickyBit;

        case (roundingMode)
            RM_NEAR_EVEN:   roundUp = guardBit & (stickyBit | norm[11]);
            RM_MIN_MAG:     roundUp = 1'b0;
            RM_MIN:         roundUp = inexact & sign;
            RM_MAX:         roundUp = inexact & ~sign;
            RM_NEAR_MAXMAG: roundUp = guardBit;
            RM_ODD:         roundUp = 1'b0;
            default:        roundUp = guardBit & (stickyBit | norm[11]);
        endcase

        fracSum  = {1'b0, norm[62:11]} + {{(SIG_W-1){1'b0}}, roundUp};
        carryOut = fracSum[SIG_W-1];
        fracOut  = fracSum[SIG_W-2:0];
        if (roundingMode == RM_ODD) fracOut[0] = fracOut[0] | inexact;

        expOut = 12'(REC_EXP_BIAS + 63) - 12'(shiftCount) + 12'(carryOut);
        if (!norm[63]) begin
            expOut  = '0;
            fracOut = '0;
        end

        recOut         = {sign & norm[63], expOut, fracOut};
        exceptionFlags = {4'b0000, inexact};
    end

endmodule

// File: rtl/int_to_rec_fn_iter.sv
// Multi-cycle 64-bit integer to recoded double converter.
// Define INT_TO_REC_FN_ITER_FAST_EN for single-edge normalization.
//
// state | meaning
// IDLE  | waiting for a request, io_in_ready high
// NORM  | left-normalizing the captured magnitude
// ROUND | rounding and registering the result
// DONE  | result valid, waiting for io_out_ready
module int_to_rec_fn_iter
    import int_to_rec_fn_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    int_to_rec_fn_iter_if.slave io
);

    localparam logic [1:0] stIdle  = IDLE;
    localparam logic [1:0] stNorm  = NORM;
    localparam logic [1:0] stRound = ROUND;
    localparam logic [1:0] stDone  = DONE;

    logic [1:0]       state;
    logic [INT_W-1:0] normReg;
    logic [5:0]       shiftCount;
    logic             signReg;
    logic [2:0]       rmReg;
    logic [REC_W-1:0] recNext;
    logic [4:0]       flagsNext;

`ifndef INT_TO_REC_FN_ITER_FAST_EN
    logic [2:0] stage;
    logic [5:0] stageK;
    logic       stageHit;

    // Stage k tests whether the top k bits are all zero.
    assign stageK   = 6'd32 >> stage;
    assign stageHit = (normReg >> (7'd64 - {1'b0, stageK})) == '0;
`endif

    assign io.io_in_ready  = (state == stIdle) & ~reset;
    assign io.io_out_valid = (state == stDone);

    rec_fn_round_pack roundPack (
        .norm           (normReg),
        .shiftCount     (shiftCount),
        .sign           (signReg),
        .roundingMode   (rmReg),
        .recOut         (recNext),
        .exceptionFlags (flagsNext)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state                         <= stIdle;
            normReg                       <= '0;
            shiftCount                    <= '0;
            signReg                       <= 1'b0;
            rmReg                         <= '0;
            io.io_out_bits_out            <= '0;
            io.io_out_bits_exceptionFlags <= '0;
`ifndef INT_TO_REC_FN_ITER_FAST_EN
            stage                         <= '0;
`endif
        end else begin
            case (state)
                stIdle: begin
                    if (io.io_in_valid) begin
                        signReg    <= io.io_in_bits_signedIn & io.io_in_bits_in[INT_W-1];
                        normReg    <= (io.io_in_bits_signedIn & io.io_in_bits_in[INT_W-1])
                                      ? (~io.io_in_bits_in + 64'd1) : io.io_in_bits_in;
                        rmReg      <= io.io_in_bits_roundingMode;
                        shiftCount <= '0;
`ifndef INT_TO_REC_FN_ITER_FAST_EN
                        stage      <= '0;
`endif
                        state      <= stNorm;
                    end
                end
                stNorm: begin
`ifdef INT_TO_REC_FN_ITER_FAST_EN
                    normReg    <= normReg << lzc64(normReg);
                    shiftCount <= lzc64(normReg);
                    state      <= stRound;
`else
                    if (stageHit) begin
                        normReg    <= normReg << stageK;
                        shiftCount <= shiftCount + stageK;
                    end
                    stage <= stage + 3'd1;
                    if (stage == 3'd5) state <= stRound;
`endif
                end
                stRound: begin
                    io.io_out_bits_out            <= recNext;
                    io.io_out_bits_exceptionFlags <= flagsNext;
                    state                         <= stDone;
                end
                stDone: begin
                    if (io.io_out_ready) state <= stIdle;
                end
                default: state <= stIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_rec_fn_iter.sv
// Scoreboard bench for int_to_rec_fn_iter: directed and random conversions
// against an arithmetic reference model, backpressure hold and reset abort.
module tb_int_to_rec_fn_iter;

`ifdef INT_TO_REC_FN_ITER_FAST_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 8;
`endif

    logic clock;
    logic reset;
    int   cycle;
    int   checkCount;
    int   passCount;
    logic randReady;
    logic prevValid;
    logic [69:0] heldResp;

    logic [69:0] expQ[$];
    int          acceptQ[$];

    int_to_rec_fn_iter_if io();

    int_to_rec_fn_iter dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Rounds the exact magnitude by comparing the dropped remainder against half an ulp.
    function automatic logic [69:0] refModel(input logic [63:0] v, input logic s, input logic [2:0] rm);
        logic        neg;
        logic [63:0] m;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        logic        inexact;
        logic        up;
        int          e;
        int          drop;
        neg = s & v[63];
        m = neg ? (64'd0 - v) : v;
        inexact = 1'b0;
        up = 1'b0;
        e = 0;
        if (m == 64'd0) return 70'd0;
        for (int i = 0; i < 64; i++) if ((m >> i) != 64'd0) e = i;
        if (e <= 52) begin
            q = m << (52 - e);
        end else begin
            drop = e - 52;
            q = m >> drop;
            rem = m - (q << drop);
            half = 64'd1 << (drop - 1);
            inexact = (rem != 64'd0);
            case (rm)
                3'd1: up = 1'b0;
                3'd2: up = inexact && neg;
                3'd3: up = inexact && !neg;
                3'd4: up = (rem >= half);
                3'd6: if (inexact) q = q | 64'd1;
                default: up = (rem > half) || ((rem == half) && q[0]);
            endcase
            q = q + 64'(up);
            if (q == (64'd1 << 53)) begin
                q = 64'd1 << 52;
                e = e + 1;
            end
        end
        return {neg, 12'(2048 + e), q[51:0], 4'b0000, inexact};
    endfunction

    task automatic issue(input logic [63:0] v, input logic s, input logic [2:0] rm,
                         input logic [69:0] exp, input bit track);
        int n;
        n = 0;
        while (!io.io_in_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) begin
            checkCount++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            return;
        end
        io.io_in_valid             = 1'b1;
        io.io_in_bits_in           = v;
        io.io_in_bits_signedIn     = s;
        io.io_in_bits_roundingMode = rm;
        @(posedge clock); #1;
        if (track) begin
            expQ.push_back(exp);
            acceptQ.push_back(cycle);
        end
        io.io_in_valid             = 1'b0;
        io.io_in_bits_in           = {$urandom, $urandom};
        io.io_in_bits_signedIn     = 1'($urandom);
        io.io_in_bits_roundingMode = 3'($urandom);
    endtask

    task automatic issueModel(input logic [63:0] v, input logic s, input logic [2:0] rm);
        issue(v, s, rm, refModel(v, s, rm), 1'b1);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (io.io_out_valid && !prevValid) begin
                heldResp = {io.io_out_bits_out, io.io_out_bits_exceptionFlags};
                if (acceptQ.size() == 0) begin
                    checkCount++;
                    $display("FAIL unexpected_valid: got 1 expected 0");
                end else begin
                    // The accepting edge counts as the first of the LAT edges.
                    check("latency", 70'(cycle - acceptQ.pop_front() + 1), 70'(LAT));
                end
            end
            if (io.io_out_valid && prevValid) begin
                check("hold_stable", {io.io_out_bits_out, io.io_out_bits_exceptionFlags}, heldResp);
                check("in_ready_in_done", 70'(io.io_in_ready), 70'd0);
            end
            if (io.io_out_valid && io.io_out_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("FAIL unexpected_result: got %h expected none", io.io_out_bits_out);
                end else begin
                    check("result", {io.io_out_bits_out, io.io_out_bits_exceptionFlags}, expQ.pop_front());
                end
            end
        end
        prevValid = io.io_out_valid;
    end

    initial forever begin
        @(posedge clock); #1;
        if (randReady) io.io_out_ready = ($urandom_range(0, 3) != 0);
    end

    logic [2:0] rmList [6];

    initial begin
        int n;
        logic [63:0] v;
        rmList = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        cycle = 0;
        checkCount = 0;
        passCount = 0;
        prevValid = 1'b0;
        heldResp = '0;
        randReady = 1'b0;
        reset = 1'b1;
        io.io_in_valid = 1'b0;
        io.io_in_bits_in = '0;
        io.io_in_bits_signedIn = 1'b0;
        io.io_in_bits_roundingMode = '0;
        io.io_out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", 70'(io.io_in_ready), 70'd0);
        check("reset_out_valid", 70'(io.io_out_valid), 70'd0);
        check("reset_out_bits", {io.io_out_bits_out, io.io_out_bits_exceptionFlags}, 70'd0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", 70'(io.io_in_ready), 70'd1);

        issue(64'd1, 1'b0, 3'd0, {65'h0_8000000000000000, 5'h00}, 1'b1);
        issue(64'd0, 1'b0, 3'd0, {65'h0, 5'h00}, 1'b1);
        issue(64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0, {65'h1_8000000000000000, 5'h00}, 1'b1);
        issue(64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0, {65'h0_8400000000000000, 5'h01}, 1'b1);
        issue(64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd1, {65'h0_83FFFFFFFFFFFFFF, 5'h01}, 1'b1);
        issue(64'h0020000000000001, 1'b0, 3'd0, {65'h0_8350000000000000, 5'h01}, 1'b1);
        issue(64'h0020000000000001, 1'b0, 3'd6, {65'h0_8350000000000001, 5'h01}, 1'b1);
        issue(64'h8000000000000000, 1'b1, 3'd0, {65'h1_83F0000000000000, 5'h00}, 1'b1);

        // Backpressure: result must hold while junk requests are presented.
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        io.io_out_ready = 1'b0;
        issueModel(64'h0123456789ABCDEF, 1'b0, 3'd4);
        n = 0;
        while (!io.io_out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("hold_valid_seen", 70'(io.io_out_valid), 70'd1);
        repeat (10) begin
            io.io_in_valid = 1'b1;
            io.io_in_bits_in = {$urandom, $urandom};
            @(posedge clock); #1;
        end
        check("hold_in_ready_low", 70'(io.io_in_ready), 70'd0);
        io.io_out_ready = 1'b1;
        @(posedge clock); #1;
        io.io_in_valid = 1'b0;
        check("in_ready_after_handshake", 70'(io.io_in_ready), 70'd1);

        // Reset three edges after acceptance discards the operation.
        issue(64'd12345, 1'b0, 3'd0, 70'd0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("abort_in_ready_in_reset", 70'(io.io_in_ready), 70'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("abort_out_bits_cleared", {io.io_out_bits_out, io.io_out_bits_exceptionFlags}, 70'd0);
        check("abort_in_ready_after", 70'(io.io_in_ready), 70'd1);
        repeat (12) @(posedge clock);
        #1;
        check("abort_no_valid", 70'(io.io_out_valid), 70'd0);
        issueModel(64'd12345, 1'b0, 3'd0);

        randReady = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: v = {$urandom, $urandom};
                1: v = 64'($urandom_range(0, 1000));
                2: v = 64'd1 << $urandom_range(0, 63);
                3: v = (64'd1 << $urandom_range(1, 63)) + 64'($urandom_range(0, 2)) - 64'd1;
                default: v = ~64'($urandom_range(0, 5));
            endcase
            issueModel(v, 1'($urandom), rmList[$urandom_range(0, 5)]);
        end

        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checkCount++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
